// File: rtl/slide_dbg_pkg.sv
// Shared definitions for the slide-stream debug capture path: FSM state
// encoding and the width helper used to size pointers and counters.
package slide_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2,
    ST_DUMP    = 2'd3
  } dbg_state_e;

  // Bits needed to address n distinct values, never less than one.
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/slide_capture_mem.sv
// Capture storage: CH lanes x DEPTH words, one full-width write port and one
// lane-selected read port with a registered output.
module slide_capture_mem
  import slide_dbg_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int CH     = 4,
  parameter int DEPTH  = 451
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_i,
  input  logic [ceil_log2(DEPTH)-1:0]  waddr_i,
  input  logic [CH*DATA_W-1:0]         wdata_i,
  input  logic                         re_i,
  input  logic [ceil_log2(DEPTH)-1:0]  raddr_i,
  input  logic [ceil_log2(CH)-1:0]     rsel_i,
  output logic [DATA_W-1:0]            rdata_o
);

  logic [CH*DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0]    rdata_q;

  // All lanes of one sample land in the same word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register only moves on a read request, so it doubles as the held output beat.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i][int'(rsel_i)*DATA_W +: DATA_W];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/slide_capture_buf.sv
// Multi-channel capture buffer: records CH lanes per in_valid strobe in
// one-shot or circular mode, then dumps enabled channels channel-major over
// a valid/ready port, oldest sample first.
module slide_capture_buf
  import slide_dbg_pkg::*;
#(
  parameter int DATA_W   = 7,
  parameter int CH       = 4,
  parameter int DEPTH    = 451,
  parameter int CIRCULAR = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arm,
  input  logic                          stop,
  input  logic                          in_valid,
  input  logic [CH*DATA_W-1:0]          in_data,
  input  logic [CH-1:0]                 ch_mask,
  input  logic                          dump,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [ceil_log2(CH)-1:0]      out_ch,
  output logic [ceil_log2(DEPTH)-1:0]   out_idx,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic [ceil_log2(DEPTH+1)-1:0] count
);

  localparam int CHW  = ceil_log2(CH);
  localparam int IDXW = ceil_log2(DEPTH);
  localparam int CNTW = ceil_log2(DEPTH + 1);
  localparam logic [IDXW-1:0] LAST_PTR  = IDXW'(DEPTH - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);
  localparam logic [IDXW:0]   DEPTH_EXT = (IDXW + 1)'(DEPTH);

  dbg_state_e      state_q, state_d;
  logic [IDXW-1:0] wr_ptr_q;
  logic            wrapped_q;
  logic [CNTW-1:0] count_q;
  logic [CH-1:0]   mask_q;
  logic [CHW-1:0]  rd_ch_q;
  logic [IDXW-1:0] rd_idx_q;
  logic            rd_more_q;
  logic            out_valid_q, out_last_q, busy_q, done_q;
  logic [CHW-1:0]  out_ch_q;
  logic [IDXW-1:0] out_idx_q;

  logic            arm_ok, wr_en, dump_go, advance, rd_at_end, nxt_found;
  logic [CHW-1:0]  first_ch, nxt_ch;
  logic [IDXW-1:0] start, rd_addr;
  logic [IDXW:0]   addr_sum;

  // Arm is honoured everywhere but DUMP and wins over a same-cycle sample.
  assign arm_ok    = arm && (state_q != ST_DUMP);
  assign wr_en     = (state_q == ST_CAPTURE) && in_valid && !arm;
  assign dump_go   = (state_q == ST_DONE) && dump && !arm;
  // A new read is issued whenever the output slot is empty or being drained.
  assign advance   = (state_q == ST_DUMP) && rd_more_q && (!out_valid_q || out_ready);
  assign rd_at_end = (CNTW'(rd_idx_q) == (count_q - CNTW'(1)));

  // Lowest enabled channel of the new mask, and next enabled channel above the cursor.
  always_comb begin
    first_ch  = '0;
    nxt_ch    = '0;
    nxt_found = 1'b0;
    for (int c = CH - 1; c >= 0; c--) begin
      if (ch_mask[c]) first_ch = CHW'(c);
      if (mask_q[c] && (CHW'(c) > rd_ch_q)) begin
        nxt_ch    = CHW'(c);
        nxt_found = 1'b1;
      end
    end
  end

  // Oldest sample sits at wr_ptr once the ring has wrapped, else at 0.
  assign start    = wrapped_q ? wr_ptr_q : '0;
  assign addr_sum = {1'b0, start} + {1'b0, rd_idx_q};
  assign rd_addr  = (addr_sum >= DEPTH_EXT) ? IDXW'(addr_sum - DEPTH_EXT) : addr_sum[IDXW-1:0];

  // Next-state selection for the capture/dump controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (arm) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (arm)                                                     state_d = ST_CAPTURE;
        else if ((CIRCULAR == 0) && in_valid && (wr_ptr_q == LAST_PTR)) state_d = ST_DONE;
        else if ((CIRCULAR != 0) && stop)                            state_d = ST_DONE;
      end
      ST_DONE: begin
        if (arm)                                                state_d = ST_CAPTURE;
        else if (dump && (ch_mask != '0) && (count_q != '0))    state_d = ST_DUMP;
      end
      ST_DUMP:    if (out_valid_q && out_ready && out_last_q) state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, capture pointers, dump cursor and the registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      count_q     <= '0;
      mask_q      <= '0;
      rd_ch_q     <= '0;
      rd_idx_q    <= '0;
      rd_more_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_CAPTURE) || (state_d == ST_DUMP);
      done_q  <= (state_d == ST_DONE);

      if (arm_ok) begin
        wr_ptr_q  <= '0;
        count_q   <= '0;
        wrapped_q <= 1'b0;
      end else if (wr_en) begin
        if (count_q != DEPTH_CNT) count_q <= count_q + CNTW'(1);
        if (wr_ptr_q == LAST_PTR) begin
          wr_ptr_q <= '0;
          if (CIRCULAR != 0) wrapped_q <= 1'b1;
        end else begin
          wr_ptr_q <= wr_ptr_q + IDXW'(1);
        end
      end

      if (dump_go) begin
        mask_q    <= ch_mask;
        rd_ch_q   <= first_ch;
        rd_idx_q  <= '0;
        rd_more_q <= 1'b1;
      end else if (advance) begin
        if (rd_at_end) begin
          rd_idx_q  <= '0;
          rd_ch_q   <= nxt_ch;
          rd_more_q <= nxt_found;
        end else begin
          rd_idx_q <= rd_idx_q + IDXW'(1);
        end
      end

      if (advance) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= rd_ch_q;
        out_idx_q   <= rd_idx_q;
        out_last_q  <= rd_at_end && !nxt_found;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  slide_capture_mem #(
    .DATA_W (DATA_W),
    .CH     (CH),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .re_i    (advance),
    .raddr_i (rd_addr),
    .rsel_i  (rd_ch_q),
    .rdata_o (out_data)
  );

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_slide_capture_buf.sv
// Bench for slide_capture_buf: a one-shot DEPTH=451 instance and a circular
// DEPTH=8 instance, checked cycle by cycle against a queue-based model.
module tb_slide_capture_buf;

  localparam int DW  = 7;
  localparam int NCH = 4;
  localparam int DA  = 451;
  localparam int DB  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, arm, stop, in_valid, dump, out_ready, sel, cmp_en;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    ch_mask;

  logic va, la, ba, dna, vb, lb, bb, dnb;
  logic [DW-1:0] dta, dtb;
  logic [1:0] cha, chb;
  logic [8:0] idxa, cnta;
  logic [2:0] idxb;
  logic [3:0] cntb;

  slide_capture_buf #(.DATA_W(DW), .CH(NCH), .DEPTH(DA), .CIRCULAR(0)) u_a (
    .clk(clk), .rst(rst), .arm(arm && !sel), .stop(stop && !sel),
    .in_valid(in_valid && !sel), .in_data(in_data), .ch_mask(ch_mask),
    .dump(dump && !sel), .out_valid(va), .out_ready(out_ready && !sel),
    .out_data(dta), .out_ch(cha), .out_idx(idxa), .out_last(la),
    .busy(ba), .done(dna), .count(cnta)
  );

  slide_capture_buf #(.DATA_W(DW), .CH(NCH), .DEPTH(DB), .CIRCULAR(1)) u_b (
    .clk(clk), .rst(rst), .arm(arm && sel), .stop(stop && sel),
    .in_valid(in_valid && sel), .in_data(in_data), .ch_mask(ch_mask),
    .dump(dump && sel), .out_valid(vb), .out_ready(out_ready && sel),
    .out_data(dtb), .out_ch(chb), .out_idx(idxb), .out_last(lb),
    .busy(bb), .done(dnb), .count(cntb)
  );

  logic          c_valid, c_last, c_busy, c_done;
  logic [DW-1:0] c_data;
  logic [1:0]    c_ch;
  logic [8:0]    c_idx, c_count;
  assign c_valid = sel ? vb : va;
  assign c_last  = sel ? lb : la;
  assign c_busy  = sel ? bb : ba;
  assign c_done  = sel ? dnb : dna;
  assign c_data  = sel ? dtb : dta;
  assign c_ch    = sel ? chb : cha;
  assign c_idx   = sel ? {6'd0, idxb} : idxa;
  assign c_count = sel ? {5'd0, cntb} : cnta;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    int data;
    int ch;
    int idx;
    bit last;
  } beat_t;

  // Model: history of every sample since arm; a dump replays the newest
  // min(n, depth) samples per enabled channel, oldest first.
  int                ph;        // 0 idle, 1 capture, 2 done, 3 dump
  bit                exp_valid;
  logic [NCH*DW-1:0] hist[$];
  beat_t             expq[$];
  beat_t             logq[$];

  function automatic int lane(input logic [NCH*DW-1:0] v, input int c);
    return int'((v >> (c * DW)) & 28'h7f);
  endfunction

  function automatic int held(input int depth);
    return (hist.size() < depth) ? hist.size() : depth;
  endfunction

  always @(posedge clk) begin
    beat_t b;
    int depth, n, base;
    depth = sel ? DB : DA;
    if (rst) begin
      ph = 0;
      exp_valid = 1'b0;
      hist.delete();
      expq.delete();
    end else begin
      case (ph)
        0: if (arm) begin ph = 1; hist.delete(); end
        1: begin
          if (arm) hist.delete();
          else begin
            if (in_valid) hist.push_back(in_data);
            if (!sel && hist.size() == depth) ph = 2;
            else if (sel && stop) ph = 2;
          end
        end
        2: begin
          if (arm) begin ph = 1; hist.delete(); end
          else if (dump) begin
            n = held(depth);
            base = hist.size() - n;
            if (ch_mask != '0 && n > 0) begin
              expq.delete();
              for (int c = 0; c < NCH; c++)
                if (ch_mask[c])
                  for (int i = 0; i < n; i++) begin
                    b.data = lane(hist[base + i], c);
                    b.ch = c;
                    b.idx = i;
                    b.last = 1'b0;
                    expq.push_back(b);
                  end
              b = expq[expq.size() - 1];
              b.last = 1'b1;
              expq[expq.size() - 1] = b;
              ph = 3;
              exp_valid = 1'b0;
            end
          end
        end
        default: begin
          if (!exp_valid) exp_valid = 1'b1;
          else if (out_ready) begin
            void'(expq.pop_front());
            if (expq.size() == 0) begin exp_valid = 1'b0; ph = 2; end
          end
        end
      endcase
    end
  end

  // Compare DUT to model on every falling edge; log accepted beats.
  always @(negedge clk) begin
    beat_t b;
    if (cmp_en) begin
      chk("busy", c_busy, (ph == 1 || ph == 3));
      chk("done", c_done, (ph == 2));
      chk("count", c_count, held(sel ? DB : DA));
      chk("out_valid", c_valid, exp_valid);
      if (exp_valid && expq.size() > 0) begin
        chk("out_data", c_data, expq[0].data);
        chk("out_ch", c_ch, expq[0].ch);
        chk("out_idx", c_idx, expq[0].idx);
        chk("out_last", c_last, expq[0].last);
      end
      if (c_valid && out_ready) begin
        b.data = int'(c_data);
        b.ch = int'(c_ch);
        b.idx = int'(c_idx);
        b.last = c_last;
        logq.push_back(b);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*DW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {7'(a3 % 128), 7'(a2 % 128), 7'(a1 % 128), 7'(a0 % 128)};
  endfunction

  task automatic wait_idle(input int budget, input bit rnd, input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      cyc();
      if (c_done && !c_busy && !c_valid) begin ok = 1'b1; break; end
    end
    out_ready = 1'b1;
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic start_dump(input logic [NCH-1:0] m);
    logq.delete();
    ch_mask = m;
    dump = 1'b1;
    cyc();
    dump = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0;
    dump = 1'b0; ch_mask = '0; out_ready = 1'b1; sel = 1'b0; cmp_en = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_count", c_count, 0);
    chk("rst_busy", c_busy, 0);
    chk("rst_done", c_done, 0);
    chk("rst_out_data", c_data, 0);
    chk("rst_out_idx", c_idx, 0);

    // One-shot fill of 451 samples, lane c = (i+c) mod 128; stop is ignored.
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < DA; i++) begin
      in_valid = 1'b1;
      in_data = pack4(i, i + 1, i + 2, i + 3);
      stop = (i == 100);
      cyc();
      if (i == 100) chk("oneshot_stop_ignored", c_busy, 1);
    end
    in_valid = 1'b0; stop = 1'b0;
    chk("oneshot_done", c_done, 1);
    chk("oneshot_count", c_count, 451);

    start_dump(4'b1111);
    wait_idle(3000, 1'b0, "oneshot_dump");
    chk("oneshot_beats", logq.size(), 1804);
    if (logq.size() == 1804) begin
      chk("oneshot_first_data", logq[0].data, 0);
      chk("oneshot_ch1_first_data", logq[451].data, 1);
      chk("oneshot_ch1_first_ch", logq[451].ch, 1);
      chk("oneshot_last_data", logq[1803].data, 69);
      chk("oneshot_last_idx", logq[1803].idx, 450);
      chk("oneshot_last_flag", logq[1803].last, 1);
      chk("oneshot_prelast_flag", logq[1802].last, 0);
    end

    // Replay the same capture under random backpressure.
    start_dump(4'b1111);
    wait_idle(12000, 1'b1, "bp_dump");
    chk("bp_beats", logq.size(), 1804);
    if (logq.size() == 1804) chk("bp_last_data", logq[1803].data, 69);

    // Reset in the middle of a dump, then a dump while idle is ignored.
    start_dump(4'b0100);
    for (int k = 0; k < 10; k++) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_valid", c_valid, 0);
    chk("midrst_busy", c_busy, 0);
    chk("midrst_done", c_done, 0);
    chk("midrst_data", c_data, 0);
    start_dump(4'b1111);
    cyc();
    chk("idle_dump_busy", c_busy, 0);
    chk("idle_dump_valid", c_valid, 0);

    // Circular DEPTH=8: 13 samples, stop, dump ch0 gives 5..12; arm mid-dump ignored.
    sel = 1'b1;
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_data = pack4(i, i + 16, i + 32, i + 64);
      cyc();
    end
    in_valid = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("circ_count", c_count, 8);
    chk("circ_done", c_done, 1);
    start_dump(4'b0001);
    cyc(); cyc();
    arm = 1'b1; cyc(); arm = 1'b0;
    wait_idle(200, 1'b0, "circ_dump");
    chk("circ_beats", logq.size(), 8);
    if (logq.size() == 8)
      for (int k = 0; k < 8; k++) begin
        chk("circ_data", logq[k].data, 5 + k);
        chk("circ_idx", logq[k].idx, k);
      end

    // Partial capture, stop together with the third sample, mask 1010.
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = pack4(i, 10 + i, 20 + i, 30 + i);
      stop = (i == 2);
      cyc();
    end
    in_valid = 1'b0; stop = 1'b0;
    chk("part_count", c_count, 3);
    chk("part_done", c_done, 1);
    start_dump(4'b1010);
    wait_idle(200, 1'b1, "part_dump");
    chk("part_beats", logq.size(), 6);
    if (logq.size() == 6) begin
      chk("part_b0_ch", logq[0].ch, 1);
      chk("part_b0_data", logq[0].data, 10);
      chk("part_b2_data", logq[2].data, 12);
      chk("part_b2_last", logq[2].last, 0);
      chk("part_b3_ch", logq[3].ch, 3);
      chk("part_b3_idx", logq[3].idx, 0);
      chk("part_b5_data", logq[5].data, 32);
      chk("part_b5_last", logq[5].last, 1);
    end

    // Arm with a same-cycle sample drops it; mask-zero dump stays in DONE.
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = pack4(50 + i, 0, 0, 0); cyc();
    end
    arm = 1'b1; in_valid = 1'b1; in_data = pack4(77, 0, 0, 0); cyc();
    arm = 1'b0; in_valid = 1'b0;
    chk("rearm_count", c_count, 0);
    chk("rearm_busy", c_busy, 1);
    in_valid = 1'b1; in_data = pack4(99, 1, 2, 3); cyc(); in_valid = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("rearm_count1", c_count, 1);
    start_dump(4'b0000);
    cyc();
    chk("mask0_done", c_done, 1);
    chk("mask0_busy", c_busy, 0);
    start_dump(4'b0001);
    wait_idle(50, 1'b0, "single_dump");
    chk("single_beats", logq.size(), 1);
    if (logq.size() == 1) begin
      chk("single_data", logq[0].data, 99);
      chk("single_last", logq[0].last, 1);
    end

    cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/slide_capture_buf.md
# slide_capture_buf

Synthesizable, parametrised capture buffer for the sliding-window data stream. It records `CH` channels of `DATA_W`-bit samples into on-chip storage, in either one-shot or circular mode. It then streams the stored samples out over a valid/ready port in channel-major order: all of channel 0, then channel 1, and so on. The block sits beside the slide-data generator and feeds a debug/UART dumper or a testbench monitor, so captures can be compared against the Python golden model without simulator file I/O.

## Interface
- `DATA_W`, 7, width of one channel sample
- `CH`, 4, number of channels captured in parallel
- `DEPTH`, 451, samples stored per channel (≥2)
- `CIRCULAR`, 0, 0 = one-shot (stop when full), 1 = circular (overwrite until `stop`)
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `arm`  in  1  pulse; IDLE/DONE → CAPTURE, clears pointers
- `stop`  in  1  pulse; CIRCULAR=1 only, CAPTURE → DONE
- `in_valid`  in  1  sample strobe for `in_data`
- `in_data`  in  `CH*DATA_W`  channel c at bits `[c*DATA_W +: DATA_W]`
- `ch_mask`  in  `CH`  per-channel dump enable, sampled on `dump`
- `dump`  in  1  pulse; DONE → DUMP
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accept
- `out_data`  out  `DATA_W`  sample
- `out_ch`  out  `$clog2(CH)` (min 1)  channel of `out_data`
- `out_idx`  out  `$clog2(DEPTH)`  sample index, 0 = oldest
- `out_last`  out  1  final sample of the whole dump
- `busy`  out  1  state ≠ IDLE and ≠ DONE
- `done`  out  1  state == DONE
- `count`  out  `$clog2(DEPTH+1)`  samples held per channel, saturates at `DEPTH`

## Operation
- FSM states: IDLE, CAPTURE, DONE, DUMP.
- **IDLE:** ignores `in_valid`, `stop` and `dump`.
- **IDLE/DONE + `arm`:** go to CAPTURE; `wr_ptr`=0, `count`=0, `wrapped`=0.
- **CAPTURE + `in_valid`:** write all `CH` lanes at `wr_ptr`, then increment `wr_ptr`.
  - `count` increments, saturating at `DEPTH`.
  - At `wr_ptr`==`DEPTH-1`:
    - CIRCULAR=0: that write happens, then go to DONE.
    - CIRCULAR=1: `wr_ptr` wraps to 0 and `wrapped`=1.
- **CAPTURE + `stop`** (CIRCULAR=1): go to DONE.
  - If `in_valid` is in the same cycle, that sample is written first.
  - With CIRCULAR=0, `stop` is ignored.
- **CAPTURE + `arm`:** restarts the capture; pointers are cleared and any `in_valid` sample in that cycle is dropped.
- **DONE + `dump`:** latch `ch_mask`.
  - If the mask is zero or `count`==0, stay in DONE.
  - Otherwise go to DUMP.
- **DUMP:** walk the enabled channels in ascending order, with `out_idx` running 0..`count-1` per channel.
  - Physical read address = (`start` + `out_idx`) mod `DEPTH`.
  - `start` = `wrapped` ? `wr_ptr` : 0.
- **Dump end:** after the handshake with `out_last`=1, return to DONE.
  - Memory contents and `count` are kept, so a repeat `dump` replays the same data.
- **`rst`:** IDLE from any state, including mid-capture or mid-dump. Storage contents are not cleared (no reset loop over the array).
- **Reset values:** `out_valid`=0, `out_data`=0, `out_ch`=0, `out_idx`=0, `out_last`=0, `busy`=0, `done`=0, `count`=0.

## Timing
- **Write path:** sample presented with `in_valid` at edge N is stored at edge N, and `count` updates at edge N.
- **Start-of-dump latency:** `dump` at edge N → DUMP at N. `out_valid`=1 with the first sample after edge N+1 (1-cycle registered read).
- **Output hold:** `out_data`/`out_ch`/`out_idx`/`out_last` stay stable while `out_valid` && !`out_ready`.
- **Throughput:** with `out_ready` held high, one sample per cycle with no bubbles, including across channel boundaries.
- **`out_valid` persistence:** `out_valid` never drops until a handshake occurs; after the last handshake it falls the next cycle.
- **`arm` during DUMP:** ignored. `dump` during CAPTURE is ignored.
- **Flags:** `busy` and `done` are registered and reflect the current state.

## Structure
- Shared package `slide_dbg_pkg`: the state enum encoding (IDLE=0, CAPTURE=1, DONE=2, DUMP=3) and a `ceil_log2` function for the pointer widths.
- One natural sub-module, `slide_capture_mem`:
  - `CH`-wide × `DEPTH` simple dual-port RAM.
  - One write port with all lanes written together.
  - One read port with a lane-select mux and a registered output.
- The top level holds the FSM, pointers and output handshake.

## Test plan
- **One-shot fill:** CIRCULAR=0, arm, then 451 samples with ch c = (i+c) mod 128.
  - Expect `done` the cycle after the 451st write and `count`=451.
  - Dump with mask 4'b1111 → 1804 beats in order, with `out_last` only on ch3 idx450.
- **Circular overwrite:** CIRCULAR=1, DEPTH=8, 13 samples 0..12 on ch0, then `stop`.
  - Dump with mask 4'b0001 → 5,6,…,12, `out_idx` 0..7.
- **Partial capture + masked dump:** CIRCULAR=1, 3 samples, stop, mask 4'b1010.
  - Expect ch1 idx0-2, then ch3 idx0-2, 6 beats total.
- **Backpressure:** toggle `out_ready` randomly.
  - Every beat is held stable while stalled; no loss or duplication against the scoreboard.
- **Reset mid-dump:** assert `rst` for 1 cycle during a dump.
  - Expect `out_valid`=0 next cycle and state IDLE.
  - Then `arm`/`dump` are honoured and a `dump` while IDLE is ignored.
- **Simultaneous events:**
  - `stop` with `in_valid` → that sample is stored.
  - `arm` during CAPTURE with `in_valid` → sample dropped and `count`=0.
  - `dump` with mask 0 → stays DONE.
